psc_trigger_frame_tx: RTL and testbench

- Sequential frame transmitter for the power-supply-controller link; successor to the fixed 10-byte trigger frame table.
- Builds SOP / payload / EOP byte streams from either a trigger pulse or a queued command (channel, code, argument).
- Streams frames over a valid/ready byte interface toward the link serializer.
- Payload length, argument width and channel width are parameterised; pending triggers are latched and take priority over commands.

---
 rtl/psc_trigger_frame_tx.sv | 250 +++++++++++++++++++++++++
 tb/tb_psc_trigger_frame_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/psc_trigger_frame_tx.sv
// Byte-serial SOP/payload/EOP frame transmitter for the power-supply-controller link.
// Optional checksum byte before EOP: define PSC_FRAME_CHECKSUM_EN.
module psc_trigger_frame_tx #(
  parameter int unsigned PAYLOAD_LEN = 8,
  parameter int unsigned ARG_W       = 32,
  parameter int unsigned CH_W        = 8,
  parameter int unsigned TRIG_CHAN   = 0,
  parameter logic [7:0]  TRIG_CODE   = 8'h30,
  parameter logic [7:0]  SOP         = 8'b001_11100,
  parameter logic [7:0]  EOP         = 8'b101_11100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_chan,
  input  logic [7:0]        cmd_code,
  input  logic [ARG_W-1:0]  cmd_arg,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              busy,
  output logic              trig_overrun
);

  localparam int unsigned ARG_BYTES = ARG_W / 8;
  localparam int unsigned CNT_W     = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

  if (PAYLOAD_LEN < 2 + ARG_BYTES) begin : g_len_chk
    $error("psc_trigger_frame_tx: PAYLOAD_LEN too small for channel, code and argument");
  end
  if ((ARG_W % 8) != 0) begin : g_arg_chk
    $error("psc_trigger_frame_tx: ARG_W must be a multiple of 8");
  end
  if (CH_W > 8) begin : g_ch_chk
    $error("psc_trigger_frame_tx: CH_W must not exceed 8");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOP     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_EOP     = 3'd3
`ifdef PSC_FRAME_CHECKSUM_EN
    , ST_CSUM  = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [7:0]          code_q, code_d;
  logic [ARG_W-1:0]    arg_q, arg_d;
  logic                trig_pend_q, trig_pend_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_sop_q, tx_sop_d;
  logic                tx_eop_q, tx_eop_d;
  logic                busy_q, busy_d;
  logic                tx_fire;
`ifdef PSC_FRAME_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  // Payload byte at index idx: channel, code, argument MSB first, then zero padding.
  function automatic logic [7:0] payload_byte(input logic [CNT_W-1:0] idx,
                                              input logic [CH_W-1:0]  ch,
                                              input logic [7:0]       cd,
                                              input logic [ARG_W-1:0] ag);
    logic [7:0]  res;
    int unsigned pos;
    pos = 32'(idx);
    if (pos == 32'd0) begin
      res = 8'(ch);
    end else if (pos == 32'd1) begin
      res = cd;
    end else if (pos < ARG_BYTES + 32'd2) begin
      res = 8'(ag >> (32'd8 * (ARG_BYTES + 32'd1 - pos)));
    end else begin
      res = 8'h00;
    end
    return res;
  endfunction

  assign tx_fire   = tx_valid_q & tx_ready;
  assign cmd_ready = rst_n & (state_q == ST_IDLE) & ~trig_pend_q & ~trig;

  // Trigger latch: in IDLE a pending trigger is consumed, while busy a second one overruns.
  always_comb begin
    trig_pend_d = trig_pend_q;
    overrun_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      trig_pend_d = trig_pend_q & trig;
      overrun_d   = 1'b0;
    end else begin
      trig_pend_d = trig_pend_q | trig;
      overrun_d   = trig_pend_q & trig;
    end
  end

  // Frame sequencing and field capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    code_d  = code_q;
    arg_d   = arg_q;
`ifdef PSC_FRAME_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trig || trig_pend_q) begin
          chan_d  = CH_W'(TRIG_CHAN);
          code_d  = TRIG_CODE;
          arg_d   = {ARG_W{1'b0}};
          state_d = ST_SOP;
        end else if (cmd_valid) begin
          chan_d  = cmd_chan;
          code_d  = cmd_code;
          arg_d   = cmd_arg;
          state_d = ST_SOP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SOP: begin
        if (tx_fire) begin
          state_d = ST_PAYLOAD;
          cnt_d   = {CNT_W{1'b0}};
`ifdef PSC_FRAME_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end else begin
          state_d = ST_SOP;
        end
      end
      ST_PAYLOAD: begin
        if (tx_fire) begin
`ifdef PSC_FRAME_CHECKSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef PSC_FRAME_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_EOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
`ifdef PSC_FRAME_CHECKSUM_EN
      ST_CSUM: begin
        if (tx_fire) begin
          state_d = ST_EOP;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_EOP: begin
        if (tx_fire) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output byte decode from the next state so every output leaves a flop; a stall holds it.
  always_comb begin
    tx_valid_d = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    tx_sop_d   = 1'b0;
    tx_eop_d   = 1'b0;
    tx_data_d  = 8'h00;
    case (state_d)
      ST_IDLE:    tx_data_d = 8'h00;
      ST_SOP: begin
        tx_data_d = SOP;
        tx_sop_d  = 1'b1;
      end
      ST_PAYLOAD: tx_data_d = payload_byte(cnt_d, chan_d, code_d, arg_d);
`ifdef PSC_FRAME_CHECKSUM_EN
      ST_CSUM:    tx_data_d = csum_d;
`endif
      ST_EOP: begin
        tx_data_d = EOP;
        tx_eop_d  = 1'b1;
      end
      default:    tx_data_d = 8'h00;
    endcase
  end

  // State, captured fields and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      chan_q      <= {CH_W{1'b0}};
      code_q      <= 8'h00;
      arg_q       <= {ARG_W{1'b0}};
      trig_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_sop_q    <= 1'b0;
      tx_eop_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PSC_FRAME_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      code_q      <= code_d;
      arg_q       <= arg_d;
      trig_pend_q <= trig_pend_d;
      overrun_q   <= overrun_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_sop_q    <= tx_sop_d;
      tx_eop_q    <= tx_eop_d;
      busy_q      <= busy_d;
`ifdef PSC_FRAME_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_sop       = tx_sop_q;
  assign tx_eop       = tx_eop_q;
  assign busy         = busy_q;
  assign trig_overrun = overrun_q;

endmodule

// File: tb/tb_psc_trigger_frame_tx.sv
// Directed self-checking bench for psc_trigger_frame_tx (default parameters).
module tb_psc_trigger_frame_tx;

`ifdef PSC_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n, trig, cmd_valid, cmd_ready;
  logic [7:0]  cmd_chan, cmd_code, tx_data;
  logic [31:0] cmd_arg;
  logic        tx_valid, tx_ready, tx_sop, tx_eop, busy, trig_overrun;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes [0:FRAME_LEN-1];
  int first_cyc, ov_cnt;

  always #5 clk = ~clk;

  psc_trigger_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .trig(trig),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy), .trig_overrun(trig_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [7:0] ch, input logic [7:0] cd, input logic [31:0] ag);
    exp_bytes[0] = 8'h3C;
    exp_bytes[1] = ch;
    exp_bytes[2] = cd;
    exp_bytes[3] = ag[31:24];
    exp_bytes[4] = ag[23:16];
    exp_bytes[5] = ag[15:8];
    exp_bytes[6] = ag[7:0];
    exp_bytes[7] = 8'h00;
    exp_bytes[8] = 8'h00;
`ifdef PSC_FRAME_CHECKSUM_EN
    exp_bytes[9]  = ch ^ cd ^ ag[31:24] ^ ag[23:16] ^ ag[15:8] ^ ag[7:0];
    exp_bytes[10] = 8'hBC;
`else
    exp_bytes[9] = 8'hBC;
`endif
  endtask

  // Collect one frame; t1/t2 are cycles on which trig pulses (0 = none).
  task automatic get_frame(input string tag, input bit toggle, input bit keep_cmd,
                           input int t1, input int t2, output int fc, output int ovc);
    int idx, cyc;
    bit stalled;
    logic [7:0] held;
    idx = 0; cyc = 0; stalled = 1'b0; held = 8'h00; fc = 0; ovc = 0;
    while (idx < FRAME_LEN && cyc < 200) begin
      @(negedge clk);
      cyc++;
      trig = (cyc == t1) || (cyc == t2);
      if (!keep_cmd) begin
        cmd_valid = 1'b0; cmd_chan = 8'hEE; cmd_code = 8'hEE; cmd_arg = 32'hDEADBEEF;
      end
      if (toggle) tx_ready = (cyc % 2 == 1);
      if (trig_overrun) ovc++;
      if (stalled) check({tag, "_stall_hold"}, {24'h0, tx_data}, {24'h0, held});
      stalled = 1'b0;
      if (tx_valid) begin
        if (fc == 0) fc = cyc;
        check({tag, "_cmd_ready_busy"}, {31'h0, cmd_ready}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        if (tx_ready) begin
          check($sformatf("%s_byte%0d", tag, idx), {24'h0, tx_data}, {24'h0, exp_bytes[idx]});
          check($sformatf("%s_sop%0d", tag, idx), {31'h0, tx_sop}, {31'h0, (idx == 0)});
          check($sformatf("%s_eop%0d", tag, idx), {31'h0, tx_eop}, {31'h0, (idx == FRAME_LEN-1)});
          idx++;
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end else if (fc != 0) begin
        check({tag, "_valid_gap"}, {31'h0, tx_valid}, 32'h1);
      end
    end
    trig = 1'b0;
    tx_ready = 1'b1;
    check({tag, "_complete"}, idx, FRAME_LEN);
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; cmd_valid = 1'b0; tx_ready = 1'b1;
    cmd_chan = 8'h00; cmd_code = 8'h00; cmd_arg = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_data", {24'h0, tx_data}, 32'h0);
    check("rst_sop_eop", {30'h0, tx_sop, tx_eop}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("rst_overrun", {31'h0, trig_overrun}, 32'h0);
    rst_n = 1'b1;
    #1 check("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // Single trigger frame
    @(negedge clk); trig = 1'b1;
    build_exp(8'h00, 8'h30, 32'h0);
    get_frame("trig", 1'b0, 1'b0, 0, 0, first_cyc, ov_cnt);
    check("trig_latency", first_cyc, 1);
    check("trig_no_overrun", ov_cnt, 0);
    @(negedge clk);
    check("trig_busy_after", {31'h0, busy}, 32'h0);
    check("trig_valid_after", {31'h0, tx_valid}, 32'h0);

    // Command frame; fields scrambled after acceptance
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 8'h05; cmd_code = 8'h21; cmd_arg = 32'h12345678;
    #1 check("cmd_ready_offer", {31'h0, cmd_ready}, 32'h1);
    build_exp(8'h05, 8'h21, 32'h12345678);
    get_frame("cmd", 1'b0, 1'b0, 0, 0, first_cyc, ov_cnt);
    check("cmd_latency", first_cyc, 1);

    // Command frame under alternating back-pressure
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 8'h0A; cmd_code = 8'h5A; cmd_arg = 32'hA1B2C3D4;
    build_exp(8'h0A, 8'h5A, 32'hA1B2C3D4);
    get_frame("stall", 1'b1, 1'b0, 0, 0, first_cyc, ov_cnt);

    // Two triggers during a command frame: one overrun, trigger frame after one idle cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 8'h07; cmd_code = 8'h44; cmd_arg = 32'h00000000;
    build_exp(8'h07, 8'h44, 32'h0);
    get_frame("ovr_cmd", 1'b0, 1'b0, 3, 6, first_cyc, ov_cnt);
    check("ovr_pulses", ov_cnt, 1);
    @(negedge clk);
    check("ovr_idle_valid", {31'h0, tx_valid}, 32'h0);
    check("ovr_idle_busy", {31'h0, busy}, 32'h0);
    build_exp(8'h00, 8'h30, 32'h0);
    get_frame("ovr_trig", 1'b0, 1'b0, 0, 0, first_cyc, ov_cnt);
    check("ovr_trig_latency", first_cyc, 1);
    repeat (3) begin
      @(negedge clk);
      check("ovr_no_extra", {31'h0, tx_valid}, 32'h0);
    end

    // Trigger and command together: trigger first, command kept offered
    @(negedge clk);
    trig = 1'b1; cmd_valid = 1'b1; cmd_chan = 8'h33; cmd_code = 8'h66; cmd_arg = 32'h01020304;
    #1 check("coinc_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    build_exp(8'h00, 8'h30, 32'h0);
    get_frame("coinc_trig", 1'b0, 1'b1, 0, 0, first_cyc, ov_cnt);
    @(negedge clk);
    check("coinc_idle_valid", {31'h0, tx_valid}, 32'h0);
    check("coinc_cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    build_exp(8'h33, 8'h66, 32'h01020304);
    get_frame("coinc_cmd", 1'b0, 1'b0, 0, 0, first_cyc, ov_cnt);
    check("coinc_cmd_latency", first_cyc, 1);

    // Reset in the middle of a frame with a trigger pending
    @(negedge clk);
    cmd_valid = 1'b1; cmd_chan = 8'h05; cmd_code = 8'h21; cmd_arg = 32'h12345678;
    build_exp(8'h05, 8'h21, 32'h12345678);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      trig = (k == 2);
    end
    check("mid_byte3", {24'h0, tx_data}, {24'h0, exp_bytes[3]});
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_no_resume", {30'h0, tx_valid, tx_eop}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
